// File: rtl/decode_pkg.sv
// decode_pkg: shared opcode constants, type-bit indices and the
// immediate-format enum used by decode_stage and imm_gen.
package decode_pkg;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_IMM_32 = 7'h1b;
    localparam logic [6:0] LOAD      = 7'h03;
    localparam logic [6:0] JALR      = 7'h67;
    localparam logic [6:0] OP        = 7'h33;
    localparam logic [6:0] OP_32     = 7'h3b;
    localparam logic [6:0] STORE     = 7'h23;
    localparam logic [6:0] BRANCH    = 7'h63;
    localparam logic [6:0] AUIPC     = 7'h17;
    localparam logic [6:0] LUI       = 7'h37;
    localparam logic [6:0] JAL       = 7'h6f;

    localparam int T_R   = 0;
    localparam int T_I   = 1;
    localparam int T_L   = 2;
    localparam int T_JR  = 3;
    localparam int T_S   = 4;
    localparam int T_SB  = 5;
    localparam int T_AUI = 6;
    localparam int T_LUI = 7;
    localparam int T_J   = 8;
    localparam int NTYPE = 9;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [NTYPE-1:0] typ;
        logic             illegal;
        imm_fmt_e         fmt;
    } dec_t;

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational immediate extraction, sign-extended to XLEN.
// Ports: i_instr (raw instruction), i_fmt (format), o_imm (immediate).
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    input  imm_fmt_e        i_fmt,
    output logic [XLEN-1:0] o_imm
);

    logic [31:0] w_imm32;
    logic        w_s;

    assign w_s = i_instr[31];

    always_comb begin
        w_imm32 = '0;
        unique case (i_fmt)
            IMM_I: w_imm32 = {{20{w_s}}, i_instr[31:20]};
            IMM_S: w_imm32 = {{20{w_s}}, i_instr[31:25], i_instr[11:7]};
            IMM_B: w_imm32 = {{19{w_s}}, w_s, i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U: w_imm32 = {i_instr[31:12], 12'h000};
            IMM_J: w_imm32 = {{11{w_s}}, w_s, i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    // Every format fits in 32 bits; wider datapaths only replicate the sign.
    if (XLEN > 32) begin : g_wide
        assign o_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_narrow
        assign o_imm = w_imm32;
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32/RV64 type decoder behind a 2-entry skid buffer.
// Ports: clk/rst/flush; in_* handshake+instr+pc; out_* decoded entry; insn_cnt.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8:0]       out_type,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] insn_cnt
);

    typedef struct packed {
        logic [8:0]      typ;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        d = '0;
        d.fmt = IMM_NONE;
        if (ins[1:0] != 2'b11) begin
            d.illegal = 1'b1;
        end else begin
            unique case (ins[6:0])
                OP_IMM: begin d.typ[T_I] = 1'b1; d.fmt = IMM_I; end
                OP_IMM_32: begin
                    if (XLEN == 64) begin
                        d.typ[T_I] = 1'b1;
                        d.fmt = IMM_I;
                    end else begin
                        d.illegal = 1'b1;
                    end
                end
                LOAD: begin
                    d.typ[T_I] = 1'b1;
                    d.typ[T_L] = 1'b1;
                    d.fmt = IMM_I;
                end
                JALR: begin
                    d.typ[T_I]  = 1'b1;
                    d.typ[T_JR] = 1'b1;
                    d.fmt = IMM_I;
                end
                OP: d.typ[T_R] = 1'b1;
                OP_32: begin
                    if (XLEN == 64) d.typ[T_R] = 1'b1;
                    else            d.illegal  = 1'b1;
                end
                STORE:  begin d.typ[T_S]   = 1'b1; d.fmt = IMM_S; end
                BRANCH: begin d.typ[T_SB]  = 1'b1; d.fmt = IMM_B; end
                AUIPC:  begin d.typ[T_AUI] = 1'b1; d.fmt = IMM_U; end
                LUI:    begin d.typ[T_LUI] = 1'b1; d.fmt = IMM_U; end
                JAL:    begin d.typ[T_J]   = 1'b1; d.fmt = IMM_J; end
                default: d.illegal = 1'b1;
            endcase
        end
        return d;
    endfunction

    dec_t            w_dec;
    logic [XLEN-1:0] w_imm;
    entry_t          w_new;
    logic            w_accept;
    logic            w_drain;

    entry_t          r_main;
    entry_t          r_skid;
    logic            r_main_vld;
    logic            r_skid_vld;
    logic [CNT_W-1:0] r_cnt;

    assign w_dec = decode(in_instr);

    imm_gen #(.XLEN(XLEN)) u_imm (
        .i_instr (in_instr),
        .i_fmt   (w_dec.fmt),
        .o_imm   (w_imm)
    );

    always_comb begin
        w_new         = '0;
        w_new.typ     = w_dec.typ;
        w_new.rd      = in_instr[11:7];
        w_new.rs1     = in_instr[19:15];
        w_new.rs2     = in_instr[24:20];
        w_new.f3      = in_instr[14:12];
        w_new.f7      = in_instr[31:25];
        w_new.imm     = w_imm;
        w_new.pc      = in_pc;
        w_new.illegal = w_dec.illegal;
    end

    // Ready depends only on the skid flag and reset, never on out_ready.
    assign in_ready = !r_skid_vld && !rst;
    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_main_vld && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_drain && r_cnt != CNT_MAX)
                r_cnt <= r_cnt + CNT_W'(1);
            if (flush) begin
                r_main_vld <= 1'b0;
                r_skid_vld <= 1'b0;
            end else if (w_drain) begin
                // Skid valid implies no accept this cycle.
                if (r_skid_vld) begin
                    r_main     <= r_skid;
                    r_skid_vld <= 1'b0;
                end else if (w_accept) begin
                    r_main <= w_new;
                end else begin
                    r_main_vld <= 1'b0;
                end
            end else if (w_accept) begin
                if (r_main_vld) begin
                    r_skid     <= w_new;
                    r_skid_vld <= 1'b1;
                end else begin
                    r_main     <= w_new;
                    r_main_vld <= 1'b1;
                end
            end
        end
    end

    assign out_valid   = r_main_vld;
    assign out_type    = r_main.typ;
    assign out_rd      = r_main.rd;
    assign out_rs1     = r_main.rs1;
    assign out_rs2     = r_main.rs2;
    assign out_funct3  = r_main.f3;
    assign out_funct7  = r_main.f7;
    assign out_imm     = r_main.imm;
    assign out_pc      = r_main.pc;
    assign out_illegal = r_main.illegal;
    assign insn_cnt    = r_cnt;

endmodule
